// File: rtl/aes_inv_round_iter.sv
// Iterative inverse AES round engine.
// Undoes NROUNDS forward rounds of the form
// SubBytes -> ShiftRows -> MixColumns -> AddRoundKey, one inverse round per clock.
// Round keys are fetched externally. rk_idx selects the forward round whose key
// is needed, and the keys are walked from the last round down to round 0.
module aes_inv_round_iter #(
    parameter int NROUNDS = 2,
    parameter int IDXW    = (NROUNDS > 1 ? $clog2(NROUNDS) : 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    in_data,
    output logic [IDXW-1:0] rk_idx,
    input  logic [127:0]    rk,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_data
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. The producer holds valid/data until that edge. Ready never
    // depends combinationally on valid.

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t          state;
    logic [IDXW-1:0] cnt;
    logic [127:0]    st;
    logic [127:0]    round_out;

    // GF(2^8) multiply, reduction polynomial 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x6   = gmul(x3, x3);
        x12  = gmul(x6, x6);
        x15  = gmul(x12, x3);
        x30  = gmul(x15, x15);
        x60  = gmul(x30, x30);
        x120 = gmul(x60, x60);
        x240 = gmul(x120, x120);
        return gmul(gmul(x240, x12), x2);
    endfunction

    // Inverse S-box: undo the affine map, then invert in the field.
    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        logic [7:0] b;
        b = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return ginv(b);
    endfunction

    // One inverse round: AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k);
        logic [127:0] x;
        logic [127:0] y;
        logic [7:0]   a [16];
        logic [7:0]   m [16];
        logic [7:0]   r [16];
        x = s ^ k;
        for (int i = 0; i < 16; i++) a[i] = x[127-8*i -: 8];
        for (int c = 0; c < 4; c++) begin
            m[4*c+0] = gmul(a[4*c], 8'h0e) ^ gmul(a[4*c+1], 8'h0b) ^ gmul(a[4*c+2], 8'h0d) ^ gmul(a[4*c+3], 8'h09);
            m[4*c+1] = gmul(a[4*c], 8'h09) ^ gmul(a[4*c+1], 8'h0e) ^ gmul(a[4*c+2], 8'h0b) ^ gmul(a[4*c+3], 8'h0d);
            m[4*c+2] = gmul(a[4*c], 8'h0d) ^ gmul(a[4*c+1], 8'h09) ^ gmul(a[4*c+2], 8'h0e) ^ gmul(a[4*c+3], 8'h0b);
            m[4*c+3] = gmul(a[4*c], 8'h0b) ^ gmul(a[4*c+1], 8'h0d) ^ gmul(a[4*c+2], 8'h09) ^ gmul(a[4*c+3], 8'h0e);
        end
        // Row rw rotates right by rw byte positions.
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                r[4*c+rw] = m[4*((c + 4 - rw) % 4) + rw];
        for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv_sbox(r[i]);
        return y;
    endfunction

    // Combinational inverse round on the working state with the fetched key.
    always_comb begin
        round_out = inv_round(st, rk);
    end

    // cnt is zero whenever the engine is not BUSY, so it doubles as the key index.
    assign rk_idx = cnt;

    // Control FSM and working state; all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            cnt       <= '0;
            st        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st       <= in_data;
                        cnt      <= IDXW'(NROUNDS - 1);
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    st <= round_out;
                    if (cnt == '0) begin
                        out_data  <= round_out;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round_iter.sv
// Bench for aes_inv_round_iter: one-round and two-round instances, checked
// against a forward-round reference model built from a generated S-box table.
module tb_aes_inv_round_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // One-round instance
    logic         in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0;
    logic [127:0] in_data1 = '0, out_data1, rk1, key1 = '0;
    logic [0:0]   rk_idx1;
    assign rk1 = key1;

    // Two-round instance
    logic         in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0;
    logic [127:0] in_data2 = '0, out_data2, rk2;
    logic [0:0]   rk_idx2;
    logic [127:0] keys2 [2];
    assign rk2 = keys2[rk_idx2];

    logic [0:0] rk_seq [$];
    logic [7:0] sbox [256];

    aes_inv_round_iter #(.NROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .rk_idx(rk_idx1), .rk(rk1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1)
    );

    aes_inv_round_iter #(.NROUNDS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .rk_idx(rk_idx2), .rk(rk2), .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
    );

    // Forward S-box generated by walking the multiplicative group with generator 3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward round: SubBytes, ShiftRows (row r left by r), MixColumns, AddRoundKey.
    function automatic logic [127:0] fwd_round(input logic [127:0] s, input logic [127:0] k);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c + r) % 4) + r];
        for (int c = 0; c < 4; c++) begin
            b[4*c+0] = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
            b[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
            b[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
            b[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Two-round driver: accept din, then count cycles until out_valid (bounded).
    task automatic exec2(input logic [127:0] din, output int lat, output logic [127:0] dout);
        in_valid2 = 1'b1;
        in_data2  = din;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        rk_seq.delete();
        while (out_valid2 !== 1'b1 && lat < 40) begin
            rk_seq.push_back(rk_idx2);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        dout = out_data2;
    endtask

    task automatic pop2();
        out_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rst_in_ready1 got=%b exp=1", in_ready1); end
        checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid1 got=%b exp=0", out_valid1); end
        checks++; if (out_data1 !== 128'h0) begin errors++; $display("FAIL rst_out_data1 got=%h exp=0", out_data1); end
        checks++; if (rk_idx1 !== 1'b0) begin errors++; $display("FAIL rst_rk_idx1 got=%b exp=0", rk_idx1); end
        checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL rst_in_ready2 got=%b exp=1", in_ready2); end
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL rst_out_valid2 got=%b exp=0", out_valid2); end
        checks++; if (out_data2 !== 128'h0) begin errors++; $display("FAIL rst_out_data2 got=%h exp=0", out_data2); end
        checks++; if (rk_idx2 !== 1'b0) begin errors++; $display("FAIL rst_rk_idx2 got=%b exp=0", rk_idx2); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_one_round();
        logic [127:0] vin [2];
        logic [127:0] vkey [2];
        int lat;
        vin[0] = {16{8'h63}}; vkey[0] = '0;
        vin[1] = {16{8'h62}}; vkey[1] = {16{8'h01}};
        for (int v = 0; v < 2; v++) begin
            key1 = vkey[v];
            in_valid1 = 1'b1;
            in_data1  = vin[v];
            @(posedge clk);
            @(negedge clk);
            in_valid1 = 1'b0;
            lat = 0;
            checks++; if (rk_idx1 !== 1'b0) begin errors++; $display("FAIL n1_rk_idx v=%0d got=%b exp=0", v, rk_idx1); end
            while (out_valid1 !== 1'b1 && lat < 40) begin
                @(posedge clk);
                @(negedge clk);
                lat++;
            end
            checks++; if (lat !== 1) begin errors++; $display("FAIL n1_latency v=%0d got=%0d exp=1", v, lat); end
            checks++; if (out_data1 !== 128'h0) begin errors++; $display("FAIL n1_data v=%0d got=%h exp=0", v, out_data1); end
            out_ready1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready1 = 1'b0;
            checks++; if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin errors++; $display("FAIL n1_release v=%0d got=%b%b exp=10", v, in_ready1, out_valid1); end
        end
    endtask

    task automatic test_two_round_fixed();
        int lat;
        logic [127:0] dout;
        keys2[0] = '0;
        keys2[1] = '0;
        exec2({16{8'h63}}, lat, dout);
        checks++; if (lat !== 2) begin errors++; $display("FAIL n2_latency got=%0d exp=2", lat); end
        checks++; if (rk_seq.size() != 2 || rk_seq[0] !== 1'b1 || rk_seq[1] !== 1'b0) begin errors++; $display("FAIL n2_rk_seq got_len=%0d exp=1,0", rk_seq.size()); end
        checks++; if (dout !== {16{8'h52}}) begin errors++; $display("FAIL n2_data got=%h exp=%h", dout, {16{8'h52}}); end
        pop2();
    endtask

    task automatic test_round_trip();
        logic [127:0] orig, ct, dout;
        int lat;
        for (int i = 0; i < 1000; i++) begin
            orig = rand128();
            keys2[0] = rand128();
            keys2[1] = rand128();
            ct = fwd_round(fwd_round(orig, keys2[0]), keys2[1]);
            exec2(ct, lat, dout);
            checks++; if (dout !== orig) begin errors++; $display("FAIL rt_data blk=%0d got=%h exp=%h", i, dout, orig); end
            checks++; if (lat !== 2) begin errors++; $display("FAIL rt_latency blk=%0d got=%0d exp=2", i, lat); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pop2();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] orig_a, orig_b, hold;
        int lat;
        keys2[0] = rand128();
        keys2[1] = rand128();
        orig_a = rand128();
        orig_b = rand128();
        exec2(fwd_round(fwd_round(orig_a, keys2[0]), keys2[1]), lat, hold);
        checks++; if (hold !== orig_a) begin errors++; $display("FAIL bp_first_data got=%h exp=%h", hold, orig_a); end
        in_valid2 = 1'b1;
        in_data2  = fwd_round(fwd_round(orig_b, keys2[0]), keys2[1]);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid2 !== 1'b1 || in_ready2 !== 1'b0) begin errors++; $display("FAIL bp_hold_flags cyc=%0d got=%b%b exp=10", c, out_valid2, in_ready2); end
            checks++; if (out_data2 !== hold) begin errors++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", c, out_data2, hold); end
        end
        out_ready2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready2 = 1'b0;
        checks++; if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin errors++; $display("FAIL bp_idle got=%b%b exp=01", out_valid2, in_ready2); end
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL bp_accept got=%b exp=0", in_ready2); end
        lat = 0;
        while (out_valid2 !== 1'b1 && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        checks++; if (lat !== 2) begin errors++; $display("FAIL bp_latency got=%0d exp=2", lat); end
        checks++; if (out_data2 !== orig_b) begin errors++; $display("FAIL bp_second_data got=%h exp=%h", out_data2, orig_b); end
        pop2();
    endtask

    task automatic test_reset_mid();
        logic [127:0] orig, dout;
        int lat;
        keys2[0] = rand128();
        keys2[1] = rand128();
        in_valid2 = 1'b1;
        in_data2  = rand128();
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL rm_out_valid got=%b exp=0", out_valid2); end
        checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL rm_in_ready got=%b exp=1", in_ready2); end
        checks++; if (out_data2 !== 128'h0) begin errors++; $display("FAIL rm_out_data got=%h exp=0", out_data2); end
        checks++; if (rk_idx2 !== 1'b0) begin errors++; $display("FAIL rm_rk_idx got=%b exp=0", rk_idx2); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL rm_no_pulse cyc=%0d got=%b exp=0", c, out_valid2); end
        end
        orig = rand128();
        exec2(fwd_round(fwd_round(orig, keys2[0]), keys2[1]), lat, dout);
        checks++; if (dout !== orig) begin errors++; $display("FAIL rm_fresh_data got=%h exp=%h", dout, orig); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL rm_fresh_latency got=%0d exp=2", lat); end
        pop2();
    endtask

    initial begin
        keys2[0] = '0;
        keys2[1] = '0;
        build_sbox();
        test_reset();
        test_one_round();
        test_two_round_fixed();
        test_round_trip();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
